saber_cbd_sampler: RTL and testbench
====================================

# saber_cbd_sampler

Centered-binomial secret sampler for the Saber coprocessor (μ = 8), sitting directly downstream of the SHAKE128 wrapper. It consumes the 64-bit pseudorandom words the wrapper emits on its `sample_dout` strobe and converts each byte into one secret coefficient reduced to 13 bits. Coefficients are packed four per 64-bit word and written to polynomial BRAM. A small elastic FIFO absorbs the wrapper's 21-word output bursts, because each input word produces two output words.

## Interface
- `N_COEFF`, 256, coefficients per polynomial; must be a multiple of 8.
- `FIFO_DEPTH`, 16, input FIFO entries; power of two, ≥ 16.
- `Q_BITS`, 13, coefficient width; each coefficient is zero-padded into a 16-bit lane.
- `clk  in  1`  single clock; all logic on posedge.
- `rst  in  1`  reset; asynchronous, active-low (asserted at 0).
- `start  in  1`  one-cycle pulse; flushes and begins a new polynomial.
- `base_addr  in  9`  output BRAM base address; latched on `start`.
- `din  in  64`  SHAKE output word.
- `din_valid  in  1`  push strobe; driven by the wrapper's `sample_dout`. There is no backpressure.
- `dout  out  64`  four packed coefficients.
- `we  out  1`  BRAM write enable for `dout`/`wt_address`.
- `wt_address  out  9`  output BRAM address.
- `done  out  1`  level; high once all `N_COEFF` coefficients are written.
- `overflow  out  1`  sticky; a word was dropped because the FIFO was full.

## Operation
- Coefficient from byte b: c = popcount(b[3:0]) − popcount(b[7:4]), giving a range of −4..4.
- c is encoded as a `Q_BITS`-bit two's complement value (mod 2^13) and placed in a 16-bit lane as {3'b0, c[12:0]}.
- Byte k of a word (`din[8k+7:8k]`) is coefficient 8w+k, where w is the input-word index since `start`.
- Each input word produces two output words, low half first:
  - bytes 0–3, then bytes 4–7;
  - coefficient 4j+i goes in `dout[16i+15:16i]` of output word j.
- State machine:
  - IDLE→RUN on `start`.
  - RUN→DONE when output word `N_COEFF/4 − 1` is written.
  - DONE→RUN on `start`.
  - `start` in RUN restarts: FIFO flushed, hold register cleared, counters zeroed, new `base_addr` latched.
- Input word counter: 0..`N_COEFF/8`. Output word counter j: 0..`N_COEFF/4 − 1`. `wt_address` = `base_addr` + j, 9-bit wrap.
- Pushes are accepted only in RUN and only while accepted input words < `N_COEFF/8`.
  - Words arriving in IDLE, in DONE, or after the quota are silently dropped and do not set `overflow`.
- FIFO:
  - Push and pop in the same cycle on a full FIFO is legal; no drop.
  - Push on full without a pop drops the word and sets `overflow`.
  - `overflow` clears only on `start` or reset.
- Unpacker: a 64-bit hold register plus a `half` bit.
  - Pops the FIFO when the hold register is empty, or in the same cycle its high half is being emitted (back-to-back).
- Reset values: `dout`=0, `we`=0, `wt_address`=0, `done`=0, `overflow`=0; state IDLE; FIFO empty.
- Reset mid-operation aborts immediately with no further writes. A subsequent `start` is required.

## Timing
- All outputs are registered.
- Latency: with the FIFO and hold register empty, a word pushed at edge k gives its low half `we`=1 in cycle k+2 and its high half in k+3.
- Throughput: sustained 1 output word per cycle, i.e. 0.5 input words per cycle.
  - A 21-word burst peaks at 11 FIFO entries, then drains during the ≥24-cycle permutation gap.
- `we` is high exactly `N_COEFF/4` cycles per polynomial.
- `done` rises the cycle after the last `we` and stays high until `start`.
- `start` takes effect at the edge it is sampled. A `din_valid` in that same cycle is dropped.

## Test plan
- Single word 0x00000000_1EFFF00F after `start` with `base_addr`=0x040 → two writes:
  - address 0x040, data 0x0002_0000_1FFC_0004;
  - address 0x041, data 0x0000_0000_0000_0000.
  - Verify the k+2/k+3 timing.
- Full polynomial: 32 back-to-back random words in bursts of 21 and 11 with a 24-cycle gap → 64 writes at `base_addr`..+63, matching a software CBD model. `done` is asserted after the last write, `overflow`=0.
- Overflow: 40 consecutive pushes with `N_COEFF`=512 → `overflow`=1, and the dropped words are exactly those pushed while the FIFO was full.
- Quota: 40 words pushed for `N_COEFF`=256 → only the first 32 are consumed, 64 writes occur, and `overflow` stays 0.
- Restart: `start` asserted at output word 10 with new `base_addr`=0x100 → no further writes to the old range, and fresh data starts at 0x100 with j=0.
- Async reset low mid-burst, between clock edges → all outputs 0 immediately, no `we` until a new `start`.

Source files
------------

// File: rtl/saber_cbd_sampler.sv
// Centered-binomial (mu = 8) secret sampler: turns SHAKE output words into packed
// 13-bit coefficients, four per 64-bit BRAM word, through a small elastic FIFO.
module saber_cbd_sampler #(
   parameter int N_COEFF    = 256,
   parameter int FIFO_DEPTH = 16,
   parameter int Q_BITS     = 13
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [8:0]  base_addr,
   input  logic [63:0] din,
   input  logic        din_valid,
   output logic [63:0] dout,
   output logic        we,
   output logic [8:0]  wt_address,
   output logic        done,
   output logic        overflow
);

   localparam int IN_WORDS  = N_COEFF / 8;
   localparam int OUT_WORDS = N_COEFF / 4;
   localparam int PTR_W     = $clog2(FIFO_DEPTH);
   localparam int IN_CW     = $clog2(IN_WORDS + 1);
   localparam int OUT_CW    = $clog2(OUT_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t            state;
   logic [63:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W:0]    count;
   logic [63:0]       hold;
   logic              hold_valid;
   logic              half;
   logic [IN_CW-1:0]  in_cnt;
   logic [OUT_CW-1:0] out_cnt;
   logic [8:0]        base;

   logic fifo_empty, fifo_full, pop, push_req, push, drop;

   // Four bytes -> four lanes of {zero pad, popcount(lo nibble) - popcount(hi nibble) mod 2^Q_BITS}.
   function automatic logic [63:0] cbd_pack(input logic [31:0] bytes4);
      logic [63:0]       lanes;
      logic [7:0]        b;
      logic [2:0]        pos, neg;
      logic [Q_BITS-1:0] coef;
      lanes = '0;
      for (int k = 0; k < 4; k++) begin
         b    = bytes4[8*k +: 8];
         pos  = 3'(b[0]) + 3'(b[1]) + 3'(b[2]) + 3'(b[3]);
         neg  = 3'(b[4]) + 3'(b[5]) + 3'(b[6]) + 3'(b[7]);
         coef = Q_BITS'(pos) - Q_BITS'(neg);
         lanes[16*k +: 16] = {{(16-Q_BITS){1'b0}}, coef};
      end
      return lanes;
   endfunction

   // Pop refills the hold register when it is empty or is releasing its high half,
   // so one output word leaves every cycle while the FIFO has data.
   always_comb begin
      fifo_empty = (count == '0);
      fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
      pop        = (state == S_RUN) && !fifo_empty && (!hold_valid || half);
      push_req   = (state == S_RUN) && din_valid && !start && (in_cnt < IN_CW'(IN_WORDS));
      push       = push_req && (!fifo_full || pop);
      drop       = push_req && fifo_full && !pop;
   end

   // NOTE: the FIFO storage has no reset; the pointers and count alone define its contents.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         hold       <= '0;
         hold_valid <= 1'b0;
         half       <= 1'b0;
         in_cnt     <= '0;
         out_cnt    <= '0;
         base       <= '0;
         dout       <= '0;
         we         <= 1'b0;
         wt_address <= '0;
         done       <= 1'b0;
         overflow   <= 1'b0;
      end else if (start) begin
         state      <= S_RUN;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         hold_valid <= 1'b0;
         half       <= 1'b0;
         in_cnt     <= '0;
         out_cnt    <= '0;
         base       <= base_addr;
         we         <= 1'b0;
         done       <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         we   <= 1'b0;
         done <= (state == S_DONE);
         if (state == S_RUN) begin
            if (hold_valid) begin
               we         <= 1'b1;
               dout       <= half ? cbd_pack(hold[63:32]) : cbd_pack(hold[31:0]);
               wt_address <= base + 9'(out_cnt);
               out_cnt    <= out_cnt + 1'b1;
               half       <= ~half;
               if (half) hold_valid <= 1'b0;
               if (out_cnt == OUT_CW'(OUT_WORDS - 1)) state <= S_DONE;
            end
            if (pop) begin
               hold       <= mem[rd_ptr];
               hold_valid <= 1'b1;
               half       <= 1'b0;
               rd_ptr     <= rd_ptr + 1'b1;
            end
            if (push) begin
               wr_ptr <= wr_ptr + 1'b1;
               in_cnt <= in_cnt + 1'b1;
            end
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            if (drop) overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_saber_cbd_sampler.sv
// Self-checking bench for saber_cbd_sampler: a 256- and a 512-coefficient instance share
// stimulus and are compared every cycle against a queue-level model of the sampler.
module tb_saber_cbd_sampler;

   logic        clk, rst, start, din_valid;
   logic [8:0]  base_addr;
   logic [63:0] din;

   logic [1:0][63:0] dout_v;
   logic [1:0][8:0]  addr_v;
   logic [1:0]       we_v, done_v, ovf_v;

   saber_cbd_sampler #(.N_COEFF(256)) u_dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .din(din),
      .din_valid(din_valid), .dout(dout_v[0]), .we(we_v[0]), .wt_address(addr_v[0]),
      .done(done_v[0]), .overflow(ovf_v[0]));

   saber_cbd_sampler #(.N_COEFF(512)) u_dut512 (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .din(din),
      .din_valid(din_valid), .dout(dout_v[1]), .we(we_v[1]), .wt_address(addr_v[1]),
      .done(done_v[1]), .overflow(ovf_v[1]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests, n_fail;

   // Model state: FIFO occupancy, hold register occupancy, list of accepted words.
   int          m_occ   [2];
   bit          m_hold  [2];
   bit          m_half  [2];
   int          m_acc_n [2];
   logic [63:0] m_acc   [2][64];
   bit          m_ovf   [2];
   bit          m_run   [2];
   logic [8:0]  m_base  [2];
   int          m_epoch;

   int          seen [2];
   int          last_epoch;
   logic [63:0] words [64];

   function automatic int quota(input int i);
      return (i == 0) ? 32 : 64;
   endfunction

   // Output word for half h of an input word, straight from the coefficient definition.
   function automatic logic [63:0] cbd_half(input logic [63:0] w, input int h);
      logic [63:0] r;
      logic [7:0]  b;
      int          c;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         b = w[8*(4*h+k) +: 8];
         c = 0;
         for (int t = 0; t < 4; t++) c = c + int'(b[t]) - int'(b[t+4]);
         r[16*k +: 16] = 16'((c + 8192) % 8192);
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic model_step();
      int occ0;
      bit pop;
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_occ[i] = 0; m_hold[i] = 0; m_half[i] = 0;
            m_acc_n[i] = 0; m_ovf[i] = 0; m_base[i] = '0;
         end
         m_epoch++;
      end else if (start) begin
         for (int i = 0; i < 2; i++) begin
            m_run[i] = 1; m_occ[i] = 0; m_hold[i] = 0; m_half[i] = 0;
            m_acc_n[i] = 0; m_ovf[i] = 0; m_base[i] = base_addr;
         end
         m_epoch++;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (m_run[i]) begin
               occ0 = m_occ[i];
               pop  = (occ0 > 0) && (!m_hold[i] || m_half[i]);
               if (m_hold[i]) begin
                  if (m_half[i]) begin m_hold[i] = 0; m_half[i] = 0; end
                  else m_half[i] = 1;
               end
               if (pop) begin m_hold[i] = 1; m_half[i] = 0; m_occ[i]--; end
               if (din_valid && m_acc_n[i] < quota(i)) begin
                  if (occ0 == 16 && !pop) m_ovf[i] = 1;
                  else begin
                     m_occ[i]++;
                     m_acc[i][m_acc_n[i]] = din;
                     m_acc_n[i]++;
                  end
               end
            end
         end
      end
   endtask

   task automatic compare_cycle();
      int j;
      if (m_epoch != last_epoch) begin
         seen[0] = 0; seen[1] = 0;
         last_epoch = m_epoch;
      end
      for (int i = 0; i < 2; i++) begin
         if (!rst) begin
            check($sformatf("rst_we%0d", i),   64'(we_v[i]),   64'd0);
            check($sformatf("rst_dout%0d", i), dout_v[i],      64'd0);
            check($sformatf("rst_addr%0d", i), 64'(addr_v[i]), 64'd0);
            check($sformatf("rst_done%0d", i), 64'(done_v[i]), 64'd0);
            check($sformatf("rst_ovf%0d", i),  64'(ovf_v[i]),  64'd0);
         end else begin
            check($sformatf("ovf%0d", i), 64'(ovf_v[i]), 64'(m_ovf[i]));
            check($sformatf("done%0d", i), 64'(done_v[i]),
                  64'(m_run[i] && seen[i] == 2 * quota(i)));
            if (we_v[i]) begin
               j = seen[i];
               if (j / 2 >= m_acc_n[i]) begin
                  n_tests++; n_fail++;
                  $display("FAIL unexpected_we%0d: got write to %0h, required no write", i, addr_v[i]);
               end else begin
                  check($sformatf("dout%0d_j%0d", i, j), dout_v[i], cbd_half(m_acc[i][j/2], j % 2));
                  check($sformatf("addr%0d_j%0d", i, j), 64'(addr_v[i]), 64'(9'(m_base[i] + 9'(j))));
               end
               seen[i]++;
            end
         end
      end
   endtask

   task automatic do_start(input logic [8:0] addr);
      @(negedge clk);
      start = 1'b1; base_addr = addr; din_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic push(input logic [63:0] w);
      din = w; din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int k = 0; k < budget && !done_v[0]; k++) @(negedge clk);
      check("done_wait", 64'(done_v[0]), 64'd1);
   endtask

   initial begin
      bit found;
      n_tests = 0; n_fail = 0; m_epoch = 0; last_epoch = 0;
      rst = 1'b0; start = 1'b0; din_valid = 1'b0; din = '0; base_addr = '0;

      fork
         forever begin
            @(posedge clk or negedge rst);
            model_step();
         end
         forever begin
            @(negedge clk);
            compare_cycle();
         end
         begin
            #200000;
            $display("FAIL watchdog: got timeout, required completion");
            $fatal(1, "watchdog expired");
         end
      join_none

      // Pin the model against the hand-decoded example word.
      check("model_pin_lo", cbd_half(64'h0000_0000_1EFF_F00F, 0), 64'h0002_0000_1FFC_0004);
      check("model_pin_hi", cbd_half(64'h0000_0000_1EFF_F00F, 1), 64'h0);
      check("model_pin_neg", cbd_half(64'hF0F0_F0F0_0000_0000, 1), 64'h1FFC_1FFC_1FFC_1FFC);

      repeat (3) @(negedge clk);
      rst = 1'b1;
      // Words while idle must be ignored.
      for (int i = 0; i < 4; i++) push({$urandom, $urandom});
      repeat (4) @(negedge clk);

      // Single word with latency check.
      do_start(9'h040);
      din = 64'h0000_0000_1EFF_F00F; din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
      check("lat_k0_we", 64'(we_v[0]), 64'd0);
      @(negedge clk);
      check("lat_k1_we", 64'(we_v[0]), 64'd0);
      @(negedge clk);
      check("lat_k2_we", 64'(we_v[0]), 64'd1);
      check("lat_k2_addr", 64'(addr_v[0]), 64'h040);
      check("lat_k2_dout", dout_v[0], 64'h0002_0000_1FFC_0004);
      @(negedge clk);
      check("lat_k3_we", 64'(we_v[0]), 64'd1);
      check("lat_k3_addr", 64'(addr_v[0]), 64'h041);
      check("lat_k3_dout", dout_v[0], 64'h0);
      @(negedge clk);
      check("lat_k4_we", 64'(we_v[0]), 64'd0);

      // Full polynomial: burst of 21, 24-cycle gap, burst of 11.
      do_start(9'($urandom_range(0, 511)));
      for (int i = 0; i < 21; i++) push({$urandom, $urandom});
      repeat (24) @(negedge clk);
      for (int i = 0; i < 11; i++) push({$urandom, $urandom});
      wait_done(200);
      repeat (3) @(negedge clk);
      check("full_writes", 64'(seen[0]), 64'd64);
      check("full_ovf", 64'(ovf_v[0]), 64'd0);

      // 40 back-to-back words: quota on the 256 instance, overflow on the 512 instance.
      do_start(9'h000);
      for (int i = 0; i < 40; i++) words[i] = {$urandom, $urandom};
      for (int i = 0; i < 40; i++) push(words[i]);
      wait_done(200);
      repeat (10) @(negedge clk);
      check("quota_writes", 64'(seen[0]), 64'd64);
      check("quota_accepted", 64'(m_acc_n[0]), 64'd32);
      check("quota_ovf", 64'(ovf_v[0]), 64'd0);
      check("ovf_flag", 64'(ovf_v[1]), 64'd1);
      check("ovf_writes", 64'(seen[1]), 64'd72);
      check("ovf_accepted", 64'(m_acc_n[1]), 64'd36);
      check("ovf_kept31", m_acc[1][31], words[31]);
      for (int d = 0; d < 4; d++)
         check($sformatf("ovf_kept%0d", 33 + 2*d), m_acc[1][32+d], words[33+2*d]);

      // Restart at output word 10 with a new base; the start-cycle word is dropped.
      do_start(9'h0A0);
      found = 0;
      for (int i = 0; i < 32 && !found; i++) begin
         din = {$urandom, $urandom}; din_valid = 1'b1;
         @(negedge clk);
         if (we_v[0] && addr_v[0] == 9'h0AA) found = 1;
      end
      check("restart_reached", 64'(found), 64'd1);
      start = 1'b1; base_addr = 9'h100; din = {$urandom, $urandom}; din_valid = 1'b1;
      @(negedge clk);
      start = 1'b0; din_valid = 1'b0;
      for (int i = 0; i < 32; i++) push({$urandom, $urandom});
      wait_done(200);
      repeat (3) @(negedge clk);
      check("restart_writes", 64'(seen[0]), 64'd64);

      // Asynchronous reset between edges in the middle of a burst.
      do_start(9'h010);
      for (int i = 0; i < 10; i++) push({$urandom, $urandom});
      din_valid = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("arst_we", 64'(we_v[0]), 64'd0);
      check("arst_dout", dout_v[0], 64'd0);
      check("arst_addr", 64'(addr_v[0]), 64'd0);
      check("arst_done", 64'(done_v[0]), 64'd0);
      check("arst_we512", 64'(we_v[1]), 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) push({$urandom, $urandom});
      repeat (10) @(negedge clk);
      check("arst_no_writes", 64'(seen[0]), 64'd0);
      check("arst_idle_done", 64'(done_v[0]), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
